// File: rtl/if_stage.sv
// if_stage: instruction fetch; owns the PC, drives the ROM address, and loads the IF/ID register
// Ports: clk, reset (sync, active-high), Stall, Redirect/RedirectPC in; InstAddr out to the ROM,
// InstIn back from it; IFID_Inst/IFID_PC/IFID_PCPlus4/IFID_Valid out. The IF_EXC_EN macro adds
// the IRQ input and the ExcPC output.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h00400000,
  parameter logic [31:0] NOP_INST = 32'h00000000
`ifdef IF_EXC_EN
  , parameter logic [31:0] EXC_VECTOR = 32'h80000004
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
`ifdef IF_EXC_EN
  input  logic        IRQ,
  output logic [31:0] ExcPC,
`endif
  output logic [31:0] InstAddr,
  input  logic [31:0] InstIn,
  output logic [31:0] IFID_Inst,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid
);
  logic [31:0] pc, pc_plus4, target;
  logic irq;
`ifdef IF_EXC_EN
  localparam logic [31:0] IRQ_PC = EXC_VECTOR;
  assign irq = IRQ;
`else
  localparam logic [31:0] IRQ_PC = RESET_PC;
  assign irq = 1'b0;
`endif
  assign InstAddr = pc;
  assign pc_plus4 = pc + 32'd4;
  // Fetch addresses are word aligned, so the redirect target drops its low two bits.
  assign target = RedirectPC & ~32'h3;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      IFID_Inst <= NOP_INST;
      IFID_PC <= '0;
      IFID_PCPlus4 <= '0;
      IFID_Valid <= 1'b0;
    end else if (irq || Redirect) begin
      pc <= irq ? IRQ_PC : target;
      IFID_Inst <= NOP_INST;
      IFID_PC <= '0;
      IFID_PCPlus4 <= '0;
      IFID_Valid <= 1'b0;
    end else if (!Stall) begin
      pc <= pc_plus4;
      IFID_Inst <= InstIn;
      IFID_PC <= pc;
      IFID_PCPlus4 <= pc_plus4;
      IFID_Valid <= 1'b1;
    end
  end
`ifdef IF_EXC_EN
  // The resume point is whatever would have entered IF/ID next: the redirect target when one is pending.
  always_ff @(posedge clk) begin
    if (reset) ExcPC <= '0;
    else if (IRQ) ExcPC <= Redirect ? target : pc;
  end
`endif
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU. Owns the program counter and drives the fetch address into the combinational instruction ROM.
- Captures the returned instruction word into the IF/ID pipeline register.
- Handles hazard stalls from the hazard unit and control-flow redirects (jump/branch) from ID/EX.

Parameters:
- RESET_PC, 32'h00400000, PC value loaded on reset.
- NOP_INST, 32'h00000000, instruction word inserted into IF/ID as a bubble.
- EXC_VECTOR, 32'h80000004, exception/interrupt entry address (used only with IF_EXC_EN).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Stall  input  1  hazard stall; hold PC and IF/ID.
- Redirect  input  1  taken branch/jump resolved downstream.
- RedirectPC  input  32  target address for Redirect.
- InstAddr  output  32  fetch address to instruction ROM (= PC).
- InstIn  input  32  instruction word returned combinationally by ROM for InstAddr.
- IFID_Inst  output  32  registered instruction.
- IFID_PC  output  32  registered PC of IFID_Inst.
- IFID_PCPlus4  output  32  registered IFID_PC+4.
- IFID_Valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
- IRQ  input  1  (IF_EXC_EN only) exception/interrupt request.
- ExcPC  output  32  (IF_EXC_EN only) PC to resume after exception.

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset; there are no async paths.
- Reset state: PC=RESET_PC, IFID_Inst=NOP_INST, IFID_PC=0, IFID_PCPlus4=0, IFID_Valid=0, ExcPC=0.
- InstAddr = PC, purely combinational. The ROM is zero-latency, so InstIn belongs to the current PC in the same cycle.
- Per-cycle priority, highest first: reset > IRQ (IF_EXC_EN) > Redirect > Stall > normal.
- Normal: PC<=PC+4, wrapping modulo 2^32. IF/ID loads {InstIn, PC, PC+4}, Valid=1.
- Stall (no Redirect): PC and all IF/ID fields hold.
- Redirect: PC<={RedirectPC[31:2],2'b00}; the low two bits are forced to zero. IF/ID loads the bubble: Inst=NOP_INST, Valid=0, PC/PCPlus4 cleared to 0. This applies even when Stall=1; Redirect overrides Stall.
- Redirect asserted for N consecutive cycles: each cycle reloads PC from RedirectPC and re-bubbles IF/ID.
- Reset asserted mid-operation: next edge forces the reset state regardless of Stall or Redirect.
- A fetch of an address with InstIn=0 (outside the programmed ROM) is still a valid instruction (Valid=1). The ROM returns 0, which decodes as sll nop.
- Fetch latency: the instruction at PC appears on IFID_* one cycle after PC is presented. Redirect penalty is one bubble in IF/ID.

Optional Feature:
- Macro IF_EXC_EN.
- Defined:
  - IRQ and ExcPC ports exist.
  - When IRQ=1 at an edge: PC<=EXC_VECTOR, IF/ID bubbled, and ExcPC<=Redirect ? {RedirectPC[31:2],2'b00} : PC. The resume point is the instruction that was about to enter IF/ID.
  - IRQ overrides Redirect and Stall.
  - ExcPC holds until the next IRQ.
- Undefined: IRQ and ExcPC ports are absent; priority is reset > Redirect > Stall > normal.

Test Plan:
- Reset then 4 free-running cycles, InstIn=PC-dependent pattern -> InstAddr 0x00400000,04,08,0C. IFID_PC lags by one cycle; IFID_Valid goes 0 then 1.
- Stall=1 for 3 cycles at PC=0x00400008 -> InstAddr and IFID_* frozen. On release, PC advances to 0x0040000C.
- Redirect=1, RedirectPC=0x00400017 -> next PC 0x00400014, IFID_Inst=0, IFID_Valid=0. The following cycle fetches 0x00400018.
- Redirect=1 and Stall=1 same cycle, RedirectPC=0x00400040 -> PC=0x00400040, IF/ID bubbled, not held.
- PC=0xFFFFFFFC, normal step -> PC wraps to 0x00000000. IFID_PCPlus4=0x00000000.
- IF_EXC_EN: IRQ=1 at PC=0x00400010 with Redirect=0 -> PC=0x80000004, ExcPC=0x00400010, IFID_Valid=0. Repeat with Redirect=1, RedirectPC=0x00400020 -> ExcPC=0x00400020.
